// File: rtl/pause_fade_ctrl.sv
// pause_fade_ctrl
//   Merges NREQ pause-request sources, the user pause toggle and the
//   OSD-open pause into a single registered CPU pause. Pause entry waits
//   for the vblank rising edge, and a watchdog forces the pause if vblank
//   never arrives. While paused, the video can be dimmed in halving steps
//   once a timeout has elapsed.
//
//   Optional macro PAUSE_FRAME_STEP_EN: builds the STEP state, which
//   releases the CPU for one frame on each frame_step rising edge. When the
//   macro is undefined, frame_step is unused and pause_state never reads 3.
//
// Ports
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   user_button    pause toggle button (rising edge)
//   frame_step     single-frame advance button (rising edge)
//   pause_request  per-source pause request [NREQ]
//   options        [0] pause when OSD open, [1] dim enable
//   OSD_STATUS     OSD open
//   vblank         core vertical blank
//   r, g, b        video in
//   pause_cpu      registered CPU pause (high only in PAUSED)
//   pause_state    RUN=0, PEND=1, PAUSED=2, STEP=3
//   dim_level      current right-shift applied to the video
//   rgb_out        {r,g,b} each shifted right by dim_level, registered
module pause_fade_ctrl #(
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int CLKSPD      = 3,
  parameter int NREQ        = 2,
  parameter int FADE_STEPS  = 2,
  parameter int DIM_CYCLES  = CLKSPD * 10000000,
  parameter int FADE_CYCLES = CLKSPD * 500000,
  parameter int PEND_CYCLES = CLKSPD * 50000
) (
  input  logic                              clk_sys,
  input  logic                              reset,
  input  logic                              user_button,
  input  logic                              frame_step,
  input  logic [NREQ-1:0]                   pause_request,
  input  logic [1:0]                        options,
  input  logic                              OSD_STATUS,
  input  logic                              vblank,
  input  logic [RW-1:0]                     r,
  input  logic [GW-1:0]                     g,
  input  logic [BW-1:0]                     b,
  output logic                              pause_cpu,
  output logic [1:0]                        pause_state,
  output logic [$clog2(FADE_STEPS+1)-1:0]   dim_level,
  output logic [RW+GW+BW-1:0]               rgb_out
);

  localparam int DLW = $clog2(FADE_STEPS + 1);

`ifdef PAUSE_FRAME_STEP_EN
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    PAUSED = 2'd2
  } state_t;
`endif

  state_t                state_q, state_d;
  logic                  pause_cpu_q;
  logic                  toggle_q;
  logic                  btn_last_q;
  logic                  vbl_last_q;
  logic [31:0]           pend_timer_q;
  logic [31:0]           dim_timer_q;
  logic [DLW-1:0]        dim_level_q;
  logic [RW+GW+BW-1:0]   rgb_q;

  logic btn_rise;
  logic vbl_rise;
  logic want;

  assign btn_rise = user_button & ~btn_last_q;
  assign vbl_rise = vblank & ~vbl_last_q;
  assign want     = (|pause_request) | toggle_q | (OSD_STATUS & options[0]);

`ifdef PAUSE_FRAME_STEP_EN
  logic step_last_q;
  logic step_rise;
  assign step_rise = frame_step & ~step_last_q;
`else
  logic unused_frame_step;
  assign unused_frame_step = frame_step;
`endif

  // Edge registers track the inputs during reset so that a level already
  // high at release is not seen as a rising edge.
  always_ff @(posedge clk_sys) begin
    btn_last_q <= user_button;
    vbl_last_q <= vblank;
`ifdef PAUSE_FRAME_STEP_EN
    step_last_q <= frame_step;
`endif
    if (reset) begin
      toggle_q <= 1'b0;
    end else if (btn_rise) begin
      toggle_q <= ~toggle_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (want) state_d = PEND;
      PEND: begin
        if (!want)
          state_d = RUN;
        else if (vbl_rise || (pend_timer_q == 32'(PEND_CYCLES - 1)))
          state_d = PAUSED;
      end
      PAUSED: begin
        if (!want)
          state_d = RUN;
`ifdef PAUSE_FRAME_STEP_EN
        else if (step_rise)
          state_d = STEP;
`endif
      end
`ifdef PAUSE_FRAME_STEP_EN
      STEP: begin
        if (!want)
          state_d = RUN;
        else if (vbl_rise)
          state_d = PAUSED;
      end
`endif
      default: state_d = RUN;
    endcase
  end

  // pause_cpu is decoded from the next state so it changes on the same edge
  // as the state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= RUN;
      pause_cpu_q  <= 1'b0;
      pend_timer_q <= '0;
    end else begin
      state_q      <= state_d;
      pause_cpu_q  <= (state_d == PAUSED);
      pend_timer_q <= (state_q == PEND) ? pend_timer_q + 32'd1 : '0;
    end
  end

  // The timer restarts at every level change: the first level needs
  // DIM_CYCLES paused clocks, each later level FADE_CYCLES more.
  always_ff @(posedge clk_sys) begin
    if (reset || (state_q != PAUSED) || !options[1]) begin
      dim_timer_q <= '0;
      dim_level_q <= '0;
    end else if (dim_level_q == '0) begin
      if (dim_timer_q == 32'(DIM_CYCLES - 1)) begin
        dim_timer_q <= '0;
        dim_level_q <= DLW'(1);
      end else begin
        dim_timer_q <= dim_timer_q + 32'd1;
      end
    end else if (dim_level_q != DLW'(FADE_STEPS)) begin
      if (dim_timer_q == 32'(FADE_CYCLES - 1)) begin
        dim_timer_q <= '0;
        dim_level_q <= dim_level_q + DLW'(1);
      end else begin
        dim_timer_q <= dim_timer_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      rgb_q <= '0;
    else
      rgb_q <= {r >> dim_level_q, g >> dim_level_q, b >> dim_level_q};
  end

  assign pause_cpu   = pause_cpu_q;
  assign pause_state = state_q;
  assign dim_level   = dim_level_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_pause_fade_ctrl.sv
module tb_pause_fade_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_button;
  logic       frame_step;
  logic [1:0] pause_request;
  logic [1:0] options;
  logic       OSD_STATUS;
  logic       vblank;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       pause_cpu;
  logic [1:0] pause_state;
  logic [1:0] dim_level;
  logic [7:0] rgb_out;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_PEND = 2'd1, S_PAUSED = 2'd2, S_STEP = 2'd3;

  pause_fade_ctrl #(
    .RW(3), .GW(3), .BW(2), .CLKSPD(1), .NREQ(2), .FADE_STEPS(2),
    .DIM_CYCLES(100), .FADE_CYCLES(10), .PEND_CYCLES(50)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
    .frame_step(frame_step), .pause_request(pause_request), .options(options),
    .OSD_STATUS(OSD_STATUS), .vblank(vblank), .r(r), .g(g), .b(b),
    .pause_cpu(pause_cpu), .pause_state(pause_state), .dim_level(dim_level),
    .rgb_out(rgb_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance n rising edges, then sample 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; user_button = 1'b0; frame_step = 1'b0; pause_request = 2'b00;
    options = 2'b00; OSD_STATUS = 1'b0; vblank = 1'b0;
    r = 3'b111; g = 3'b110; b = 2'b11;
    tick(2);
    chk("rst_state", 32'(pause_state), 32'(S_RUN));
    chk("rst_cpu", 32'(pause_cpu), 32'd0);
    chk("rst_dim", 32'(dim_level), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'h00);
    reset = 1'b0;
    tick(1);
    chk("idle_state", 32'(pause_state), 32'(S_RUN));

    // 1. vblank-aligned entry
    pause_request = 2'b01;
    tick(1);
    chk("t1_pend", 32'(pause_state), 32'(S_PEND));
    chk("t1_pend_cpu", 32'(pause_cpu), 32'd0);
    tick(19);
    chk("t1_still_pend", 32'(pause_state), 32'(S_PEND));
    vblank = 1'b1;
    tick(1);
    chk("t1_paused", 32'(pause_state), 32'(S_PAUSED));
    chk("t1_cpu", 32'(pause_cpu), 32'd1);
    vblank = 1'b0;
    pause_request = 2'b00;
    tick(1);
    chk("t1_release_state", 32'(pause_state), 32'(S_RUN));
    chk("t1_release_cpu", 32'(pause_cpu), 32'd0);

    // 2. watchdog: PAUSED exactly 50 clocks after PEND entry
    pause_request = 2'b10;
    tick(1);
    chk("t2_pend", 32'(pause_state), 32'(S_PEND));
    tick(49);
    chk("t2_pend_49", 32'(pause_state), 32'(S_PEND));
    tick(1);
    chk("t2_paused_50", 32'(pause_state), 32'(S_PAUSED));
    chk("t2_cpu", 32'(pause_cpu), 32'd1);

    // 3. fade while paused
    options = 2'b10;
    tick(1);
    chk("t3_rgb0", 32'(rgb_out), 32'hFB);
    chk("t3_dim0", 32'(dim_level), 32'd0);
    tick(98);
    chk("t3_dim_99", 32'(dim_level), 32'd0);
    tick(1);
    chk("t3_dim1", 32'(dim_level), 32'd1);
    chk("t3_rgb_lat", 32'(rgb_out), 32'hFB);
    tick(1);
    chk("t3_rgb1", 32'(rgb_out), 32'h6D);
    tick(8);
    chk("t3_dim1_hold", 32'(dim_level), 32'd1);
    tick(1);
    chk("t3_dim2", 32'(dim_level), 32'd2);
    tick(1);
    chk("t3_rgb2", 32'(rgb_out), 32'h24);
    tick(20);
    chk("t3_dim_sat", 32'(dim_level), 32'd2);
    chk("t3_rgb_sat", 32'(rgb_out), 32'h24);
    options = 2'b00;
    tick(1);
    chk("t3_dim_clr", 32'(dim_level), 32'd0);
    tick(1);
    chk("t3_rgb_clr", 32'(rgb_out), 32'hFB);

    // 4. toggle and reset
    pause_request = 2'b00;
    tick(1);
    chk("t4_run", 32'(pause_state), 32'(S_RUN));
    user_button = 1'b1;
    tick(1);
    chk("t4_btn_edge", 32'(pause_state), 32'(S_RUN));
    user_button = 1'b0;
    tick(1);
    chk("t4_pend", 32'(pause_state), 32'(S_PEND));
    vblank = 1'b1;
    tick(1);
    chk("t4_paused", 32'(pause_state), 32'(S_PAUSED));
    vblank = 1'b0;
    reset = 1'b1;
    user_button = 1'b1;
    tick(1);
    chk("t4_rst_state", 32'(pause_state), 32'(S_RUN));
    chk("t4_rst_cpu", 32'(pause_cpu), 32'd0);
    reset = 1'b0;
    tick(3);
    chk("t4_after_rst", 32'(pause_state), 32'(S_RUN));
    user_button = 1'b0;
    tick(1);
    chk("t4_btn_low", 32'(pause_state), 32'(S_RUN));

    // reset mid-pause with a request still held re-enters PEND
    pause_request = 2'b01;
    tick(1);
    vblank = 1'b1;
    tick(1);
    chk("t4b_paused", 32'(pause_state), 32'(S_PAUSED));
    vblank = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("t4b_rst", 32'(pause_state), 32'(S_RUN));
    reset = 1'b0;
    tick(1);
    chk("t4b_repend", 32'(pause_state), 32'(S_PEND));
    vblank = 1'b1;
    tick(1);
    chk("t5_paused", 32'(pause_state), 32'(S_PAUSED));
    vblank = 1'b0;

    // 5. frame step
`ifdef PAUSE_FRAME_STEP_EN
    frame_step = 1'b1;
    tick(1);
    chk("t5_step", 32'(pause_state), 32'(S_STEP));
    chk("t5_step_cpu", 32'(pause_cpu), 32'd0);
    frame_step = 1'b0;
    tick(1);
    chk("t5_step_hold", 32'(pause_state), 32'(S_STEP));
    vblank = 1'b1;
    tick(1);
    chk("t5_repaused", 32'(pause_state), 32'(S_PAUSED));
    chk("t5_repaused_cpu", 32'(pause_cpu), 32'd1);
    vblank = 1'b0;
    tick(1);
    frame_step = 1'b1;
    pause_request = 2'b00;
    tick(1);
    chk("t5_drop_prio", 32'(pause_state), 32'(S_RUN));
    frame_step = 1'b0;
`else
    frame_step = 1'b1;
    tick(1);
    chk("t5_nostep", 32'(pause_state), 32'(S_PAUSED));
    chk("t5_nostep_cpu", 32'(pause_cpu), 32'd1);
    frame_step = 1'b0;
    pause_request = 2'b00;
    tick(1);
    chk("t5_drop", 32'(pause_state), 32'(S_RUN));
`endif

    // 6. OSD pause
    OSD_STATUS = 1'b1;
    options = 2'b00;
    tick(3);
    chk("t6_osd_off", 32'(pause_state), 32'(S_RUN));
    options = 2'b01;
    tick(1);
    chk("t6_pend", 32'(pause_state), 32'(S_PEND));
    vblank = 1'b1;
    tick(1);
    chk("t6_paused", 32'(pause_state), 32'(S_PAUSED));
    vblank = 1'b0;
    OSD_STATUS = 1'b0;
    tick(1);
    chk("t6_close", 32'(pause_state), 32'(S_RUN));
    chk("t6_close_cpu", 32'(pause_cpu), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pause_fade_ctrl.md
Name: pause_fade_ctrl

Overview:
- Next-generation pause controller for arcade cores. Merges NREQ pause-request sources, the user pause toggle and OSD-open pause into one CPU pause signal.
- Pause entry is aligned to the vblank rising edge, with a watchdog fallback if vblank never arrives.
- While paused, RGB dims progressively in FADE_STEPS halving stages after a timeout.
- Sits between the core, the HPS/OSD status and arcade_video.

Parameters:
- RW, 3, red channel width
- GW, 3, green channel width
- BW, 2, blue channel width
- CLKSPD, 3, clk_sys frequency in MHz
- NREQ, 2, number of pause_request inputs (>=1)
- FADE_STEPS, 2, maximum dim level (right-shift count); must be <= min(RW,GW,BW)
- DIM_CYCLES, CLKSPD*10000000, clocks in PAUSED before dim level 1
- FADE_CYCLES, CLKSPD*500000, clocks between successive dim levels
- PEND_CYCLES, CLKSPD*50000, watchdog clocks in PEND before forced pause

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- user_button  in  1  user pause button, active-high, rising-edge toggles
- frame_step  in  1  single-frame advance button, rising-edge
- pause_request  in  NREQ  per-source pause request, active-high
- options  in  2  [0] pause when OSD open, [1] dim enable
- OSD_STATUS  in  1  OSD open
- vblank  in  1  core vertical blank, clk_sys domain
- r / g / b  in  RW / GW / BW  video in
- pause_cpu  out  1  registered CPU pause
- pause_state  out  2  RUN=0, PEND=1, PAUSED=2, STEP=3
- dim_level  out  clog2(FADE_STEPS+1)  current shift count
- rgb_out  out  RW+GW+BW  {r,g,b} each >> dim_level, registered

Behaviour:
- Reset (synchronous, active-high; clock clk_sys): state=RUN, pause_toggle=0, pause_cpu=0, dim_level=0, timers=0, rgb_out=0. Button and vblank edge registers load current input values during reset, so no edge is detected on the first cycle after release.
- Edge detect: x_rise = x & ~x_last, applied to user_button, frame_step and vblank.
- user_button rise toggles pause_toggle. It is ignored while reset is high.
- want = |pause_request | pause_toggle | (OSD_STATUS & options[0]).
- FSM, all transitions on the clock edge following the qualifying condition:
  - RUN: want -> PEND.
  - PEND: !want -> RUN (has priority). Else vblank_rise -> PAUSED. Else pend_timer == PEND_CYCLES-1 -> PAUSED (watchdog). pend_timer clears whenever the state is not PEND.
  - PAUSED: !want -> RUN (priority over step). Else frame_step rise -> STEP.
  - STEP: !want -> RUN. Else vblank_rise -> PAUSED. frame_step is ignored in STEP.
- pause_cpu is 1 exactly when the state is PAUSED. It is registered on the same edge as the state, so there is no extra latency.
- Dim timer is 32-bit and counts only in PAUSED with options[1]=1. Leaving PAUSED, or options[1]=0, clears the timer and dim_level on the next clock.
- dim_level 0->1 on the DIM_CYCLES-th PAUSED clock. Each further FADE_CYCLES clocks, dim_level increments, saturating at FADE_STEPS; the timer then holds.
- rgb_out has 1-clock latency, always (including dim_level 0). Shift is a logical right shift per channel.
- Reset mid-pause returns to RUN immediately and clears pause_toggle. If pause_request is still high after release, the FSM re-enters PEND.

Optional Feature:
- Macro: PAUSE_FRAME_STEP_EN.
- Defined: STEP state and frame_step behaviour exactly as above.
- Undefined: STEP state is not built. frame_step is an unused input. PAUSED leaves only via !want. pause_state never reads 3.

Test Plan:
Bench parameters: CLKSPD=1, DIM_CYCLES=100, FADE_CYCLES=10, PEND_CYCLES=50, NREQ=2, FADE_STEPS=2.
1. Frame alignment: pause_request=2'b01 at T0, vblank rises at T0+20 -> state PEND from T0+1, PAUSED and pause_cpu=1 from T0+21. Drop request -> pause_cpu=0 next clock.
2. Watchdog: pause_request=2'b10, vblank held 0 -> PAUSED exactly 50 clocks after PEND entry.
3. Fade: paused, options=2'b10, r=3'b111, g=3'b110, b=2'b11 -> rgb_out=8'hFB. 100 clocks later dim_level=1, rgb_out={3'b011,3'b011,2'b01}. 10 clocks later dim_level=2, rgb_out={3'b001,3'b001,2'b00}. Holds at level 2. Clearing options[1] -> dim_level=0 next clock.
4. Toggle and reset: user_button pulse then vblank -> PAUSED. Assert reset 1 clock -> RUN, pause_toggle=0, pause_cpu=0. After release stays RUN with no requests.
5. Frame step (macro defined): in PAUSED, frame_step rise -> STEP, pause_cpu=0. Next vblank rise -> PAUSED. Frame_step rise and request drop in the same cycle -> RUN.
6. OSD pause: OSD_STATUS=1 with options[0]=0 -> stays RUN. Set options[0]=1 -> PEND, then PAUSED at the next vblank rise.
